// File: rtl/dice_pkg.sv
// Shared definitions for the die-result display path: FSM states,
// digit/BCD sizing, seven-segment codes and the double-dabble adjust step.
package dice_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 3;
    localparam int BCD_W      = 12;

    // Active-high segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_OFF = 7'h00;

    // One double-dabble correction: every nibble >= 5 gets +3 so that the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/roll_display_if.sv
// Value/handshake bundle between the die roller side and the display block.
interface roll_display_if;
    import dice_pkg::*;

    logic [7:0]       num_in;
    logic             num_valid;
    logic             busy;
    logic [BCD_W-1:0] bcd_out;

    // Producer: the upstream roller (or a bench) presenting results
    modport master (
        output num_in,
        output num_valid,
        input  busy,
        input  bcd_out
    );

    // Consumer: the display block
    modport slave (
        input  num_in,
        input  num_valid,
        output busy,
        output bcd_out
    );

endinterface

// File: rtl/roll_display_seg7_decode.sv
// Combinational nibble to seven-segment decoder; non-decimal nibbles are dark.
module seg7_decode
    import dice_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Pure lookup of the segment pattern for one decimal digit
    always_comb begin
        o_seg = SEG_OFF;
        case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/roll_display.sv
// Die result display: converts an 8-bit value to BCD with a sequential
// double-dabble engine and scans it onto a 3-digit multiplexed 7-seg display.
// num_valid arrives from the roller's roll-edge pulse delayed by one cycle.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for num_valid; bcd_out holds the last result
//   ST_SHIFT | 8 double-dabble iterations, one per clock
//   ST_LATCH | scratch BCD copied to bcd_out, back to idle next edge
module roll_display
    import dice_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
)(
    input  logic           clk,
    input  logic           rst_n,
    roll_display_if.slave  bus,
    output logic [6:0]     seg,
    output logic [2:0]     dig_en
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    state_t           r_state;
    logic [7:0]       r_shift;
    logic [BCD_W-1:0] r_scratch;
    logic [2:0]       r_iter;
    logic [BCD_W-1:0] r_bcd;

    logic [CNT_W-1:0] r_scan_cnt;
    logic [2:0]       r_dig_en;
    logic [6:0]       r_seg;

    logic [BCD_W-1:0] w_adj;
    logic             w_wrap;
    logic [2:0]       w_dig_next;
    logic [3:0]       w_nibble;
    logic             w_blank;
    logic [6:0]       w_seg_dec;

    assign w_adj = dd_adjust(r_scratch);

    // Conversion FSM: capture, shift/adjust for 8 cycles, then latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_iter    <= '0;
            r_bcd     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.num_valid) begin
                        r_shift   <= bus.num_in;
                        r_scratch <= '0;
                        r_iter    <= '0;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {r_scratch, r_shift} <= {w_adj, r_shift} << 1;
                    r_iter <= r_iter + 3'd1;
                    if (r_iter == 3'd7) begin
                        r_state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    r_bcd   <= r_scratch;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.bcd_out = r_bcd;

    // Next digit slot: rotate the one-hot enable when the refresh count wraps
    assign w_wrap     = (r_scan_cnt == CNT_MAX);
    assign w_dig_next = w_wrap ? {r_dig_en[1:0], r_dig_en[2]} : r_dig_en;

    // Digit mux plus leading-zero blanking for the slot about to be shown
    always_comb begin
        w_nibble = r_bcd[3:0];
        w_blank  = 1'b0;
        case (w_dig_next)
            3'b010: begin
                w_nibble = r_bcd[7:4];
                w_blank  = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
            end
            3'b100: begin
                w_nibble = r_bcd[11:8];
                w_blank  = (r_bcd[11:8] == 4'd0);
            end
            default: begin
                w_nibble = r_bcd[3:0];
                w_blank  = 1'b0;
            end
        endcase
    end

    seg7_decode u_seg7_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_dec)
    );

    // Free-running scan: refresh counter, digit enable and segments register together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_dig_en   <= 3'b001;
            r_seg      <= SEG_0;
        end else begin
            r_scan_cnt <= w_wrap ? '0 : r_scan_cnt + CNT_W'(1);
            r_dig_en   <= w_dig_next;
            r_seg      <= w_blank ? SEG_OFF : w_seg_dec;
        end
    end

    assign seg    = r_seg;
    assign dig_en = r_dig_en;

endmodule

// File: tb/tb_roll_display.sv
// Self-checking bench for roll_display with REFRESH_DIV=4.
module tb_roll_display;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg;
    logic [2:0] dig_en;

    roll_display_if bus ();

    roll_display #(.REFRESH_DIV(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .seg    (seg),
        .dig_en (dig_en)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal digits by plain arithmetic
    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] codes [10];
        codes = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (d < 4'd10) return codes[d];
        return 7'h00;
    endfunction

    // What a display slot shows for a given number: 0 ones, 1 tens, 2 hundreds
    function automatic logic [6:0] slot_seg(input logic [11:0] b, input int slot);
        if (slot == 2) return (b[11:8] == 0) ? 7'h00 : seg_code(b[11:8]);
        if (slot == 1) return (b[11:8] == 0 && b[7:4] == 0) ? 7'h00 : seg_code(b[7:4]);
        return seg_code(b[3:0]);
    endfunction

    // Behavioural model: conversion as a 9-cycle busy window, scan as edge count
    int          m_cyc = 0;
    int          m_rem = 0;
    int          m_val = 0;
    logic [11:0] m_bcd = 12'h000;
    logic [6:0]  m_seg = 7'h3F;
    logic [2:0]  m_dig = 3'b001;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_rem = 0; m_bcd = 12'h000; m_seg = 7'h3F; m_dig = 3'b001;
        end else begin
            int slot;
            m_cyc++;
            slot  = (m_cyc / 4) % 3;
            m_dig = 3'(1 << slot);
            m_seg = slot_seg(m_bcd, slot);
            if (m_rem == 0) begin
                if (bus.num_valid) begin
                    m_rem = 9;
                    m_val = int'(bus.num_in);
                end
            end else begin
                m_rem--;
                if (m_rem == 0) m_bcd = to_bcd(m_val);
            end
        end
    end

    // Every-cycle compare against the model
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("cyc_busy",   12'(bus.busy), 12'(m_rem != 0));
            chk("cyc_bcd",    bus.bcd_out, m_bcd);
            chk("cyc_dig_en", 12'(dig_en), 12'(m_dig));
            chk("cyc_seg",    12'(seg), 12'(m_seg));
        end
    end

    task automatic strobe_now(input logic [7:0] v);
        bus.num_in    = v;
        bus.num_valid = 1'b1;
        @(posedge clk);
        #2;
        bus.num_valid = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] v);
        @(posedge clk);
        #2;
        strobe_now(v);
    endtask

    task automatic check_slot(input logic [2:0] en, input logic [6:0] exp, input string name);
        int n = 0;
        while (dig_en !== en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_en"}, 12'(dig_en), 12'(en));
        chk(name, 12'(seg), 12'(exp));
    endtask

    initial begin
        logic [2:0] scan_exp [16];
        int busy_cycles;
        scan_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010,
                     3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b001, 3'b001};
        bus.num_in    = 8'd0;
        bus.num_valid = 1'b0;
        #17 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_busy",   12'(bus.busy), 12'h000);
        chk("rst_bcd",    bus.bcd_out, 12'h000);
        chk("rst_dig_en", 12'(dig_en), 12'h001);
        chk("rst_seg",    12'(seg), 12'h03F);

        // 20: busy window and slot contents
        strobe(8'd20);
        busy_cycles = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.busy) busy_cycles++;
        end
        chk("busy_len_20", 12'(busy_cycles), 12'd9);
        chk("bcd_20", bus.bcd_out, 12'h020);
        repeat (2) @(negedge clk);
        check_slot(3'b001, 7'h3F, "seg20_ones");
        check_slot(3'b010, 7'h5B, "seg20_tens");
        check_slot(3'b100, 7'h00, "seg20_hund");

        // 7: two leading digits blanked
        strobe(8'd7);
        repeat (9) @(posedge clk);
        #1 chk("bcd_7", bus.bcd_out, 12'h007);
        repeat (2) @(negedge clk);
        check_slot(3'b010, 7'h00, "seg7_tens");
        check_slot(3'b100, 7'h00, "seg7_hund");
        check_slot(3'b001, 7'h07, "seg7_ones");

        // 255 with a dropped strobe at T3, then back-to-back 4 at T10
        strobe(8'd255);
        @(posedge clk);
        strobe(8'd4);
        repeat (6) @(posedge clk);
        #1 chk("bcd_255", bus.bcd_out, 12'h255);
        chk("busy_at_t9", 12'(bus.busy), 12'h000);
        #1 strobe_now(8'd4);
        repeat (9) @(posedge clk);
        #1 chk("bcd_4_b2b", bus.bcd_out, 12'h004);

        // Asynchronous reset mid-conversion
        strobe(8'd123);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bcd",    bus.bcd_out, 12'h000);
        chk("arst_busy",   12'(bus.busy), 12'h000);
        chk("arst_dig_en", 12'(dig_en), 12'h001);
        chk("arst_seg",    12'(seg), 12'h03F);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Idle scan sequence from reset release
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("scan_seq", 12'(dig_en), 12'(scan_exp[k]));
        end
        chk("no_partial_latch", bus.bcd_out, 12'h000);

        // Exhaustive conversion
        for (int n = 0; n < 256; n++) begin
            strobe(8'(n));
            repeat (9) @(posedge clk);
            #1 chk("bcd_exh", bus.bcd_out, to_bcd(n));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/roll_display.md
ROLL_DISPLAY -- requirements
Module: roll_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clk cycles each digit is enabled before the scan advances (legal range 2..2^20).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset: asynchronous assert, active-low.
REQ-004 num_in  input  8  unsigned value to display (die result, 0..255 accepted).
REQ-005 num_valid  input  1  single-cycle strobe, num_in valid this cycle.
REQ-006 busy  output  1  high while a conversion is in progress; strobes are ignored then.
REQ-007 bcd_out  output  12  latched BCD result {hundreds, tens, ones}, 4 bits each.
REQ-008 seg  output  7  active-high segments {g,f,e,d,c,b,a} for the currently enabled digit.
REQ-009 dig_en  output  3  one-hot active-high digit enable: bit0 ones, bit1 tens, bit2 hundreds.

Function
REQ-010 FSM states: IDLE, SHIFT, LATCH; reset state IDLE.
REQ-011 IDLE and num_valid=1 at edge T0: capture num_in into an 8-bit shift register, clear the 12-bit scratch BCD, clear the iteration counter, go to SHIFT.
REQ-012 SHIFT: one double-dabble iteration per clock: add 3 to each scratch nibble >=5, then shift {scratch, shift register} left by 1 bit.
REQ-013 SHIFT lasts exactly 8 cycles (edges T1..T8), then goes to LATCH.
REQ-014 LATCH at edge T9: copy scratch into bcd_out, return to IDLE; latency from strobe to updated bcd_out is 9 cycles.
REQ-015 busy is high exactly in SHIFT and LATCH (from after T0 through T9), decoded from the registered state.
REQ-016 num_valid while busy=1 is dropped, with no queueing and no effect on the conversion in progress.
REQ-017 num_valid in the cycle after LATCH (IDLE) is accepted normally; back-to-back conversions every 10 cycles.
REQ-018 bcd_out holds its value between conversions; the display never shows a partial result.
REQ-019 Scan counter counts 0..REFRESH_DIV-1 continuously, independent of the FSM; on wrap the digit index advances ones->tens->hundreds->ones.
REQ-020 dig_en is always exactly one-hot and is registered together with seg, so both change on the same edge.
REQ-021 Segment codes, digits 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex); nibble values 10..15 give 00.
REQ-022 Leading-zero blanking: hundreds seg=00 if hundreds=0; tens seg=00 if hundreds=0 and tens=0; ones is never blanked.
REQ-023 A blanked digit keeps its dig_en bit asserted during its slot.

Reset
REQ-024 On rst_n low: state IDLE, busy=0, bcd_out=000, shift/scratch/iteration counter=0, scan counter=0, dig_en=001, seg=3F.
REQ-025 Reset asserted mid-conversion aborts it; bcd_out returns to 000 and no partial value is ever latched.
REQ-026 The first strobe after reset release is accepted in the first cycle rst_n is sampled high.

Structure
REQ-027 Shared package dice_pkg holds: the FSM state enum, constant NUM_DIGITS=3, constant BCD_W=12, and the ten segment code constants.
REQ-028 Segment decoding is a combinational sub-module seg7_decode (4-bit nibble in, 7-bit seg out), instantiated once after the digit mux.
REQ-029 The block is placed downstream of the die roller; num_valid is driven by that roller's roll-edge pulse delayed one cycle.

Verification (REFRESH_DIV=4 in the bench)
REQ-030 Strobe num_in=20 -> busy high for 9 cycles, bcd_out=020 at T9, seg ones=3F, tens=5B, hundreds=00.
REQ-031 Strobe num_in=7 -> bcd_out=007; tens and hundreds slots seg=00; ones slot seg=07.
REQ-032 Strobe 255, then strobe 4 at T3 -> bcd_out=255; 4 is ignored; a strobe 4 at T10 gives bcd_out=004 at T19.
REQ-033 Strobe 123, assert rst_n low at T5 -> bcd_out=000, busy=0, dig_en=001, seg=3F immediately (asynchronous).
REQ-034 Idle scan -> dig_en sequence 001,010,100,001, each held exactly 4 cycles; never zero and never multi-hot.
REQ-035 Exhaustive: every num_in 0..255 -> bcd_out equals its decimal digits.
